mem_access_ctrl: RTL

// - Initiator side of the DataMemory port. Sits between the CPU datapath and DataMemory.
// - Accepts one byte/half/word load or store request at a time and drives the word-wide

---
 rtl/mem_access_ctrl_pkg.sv | 28 ++
 rtl/mem_access_ctrl_byte_lane_unit.sv | 62 ++++++
 rtl/mem_access_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the DataMemory initiator: request size codes,
// controller state encoding and the alignment fault rule.
package mem_access_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    // A request faults when its size code is illegal or the address is not
    // naturally aligned for that size.
    function automatic logic req_faults(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            SZ_WORD: return |lane;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_byte_lane_unit.sv
// Little-endian byte-lane steering: merges a sub-word store into the word
// read from memory, and extracts/extends a sub-word load. Purely combinational.
module byte_lane_unit
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_merged,
    output logic [31:0] o_load
);

    logic [4:0]  w_shamt;
    logic [31:0] w_mask;
    logic [31:0] w_ins;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Bit offset of the addressed lane; halves snap to the 16-bit boundary
    always_comb begin
        w_shamt = (i_size == SZ_HALF) ? {i_lane[1], 4'b0000} : {i_lane, 3'b000};
    end

    // Store merge: replace only the addressed lane(s); word stores pass through
    always_comb begin
        w_mask   = 32'h0;
        w_ins    = 32'h0;
        o_merged = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                w_mask   = 32'h0000_00FF << w_shamt;
                w_ins    = {24'h0, i_wdata[7:0]} << w_shamt;
                o_merged = (i_word & ~w_mask) | w_ins;
            end
            SZ_HALF: begin
                w_mask   = 32'h0000_FFFF << w_shamt;
                w_ins    = {16'h0, i_wdata[15:0]} << w_shamt;
                o_merged = (i_word & ~w_mask) | w_ins;
            end
            default: o_merged = i_wdata;
        endcase
    end

    // Load extract with sign or zero fill; word loads ignore the signed flag
    always_comb begin
        case (i_lane)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
        case (i_size)
            SZ_BYTE: o_load = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_load = {{16{i_signed & w_half[15]}}, w_half};
            default: o_load = i_word;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the DataMemory port. Accepts one load/store at a time,
// performs read-modify-write for sub-word stores, faults misaligned requests
// before they reach memory, and returns extended load data.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int MEM_RD_LAT = 1,   // cycles MemRead is held, legal 1..4
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [1:0]        ReqSize,
    input  logic              ReqSigned,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [31:0]       ReqWData,
    output logic              RespValid,
    output logic [31:0]       RespRData,
    output logic              RespFault,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [31:0]       MemWriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [31:0]       MemReadData
);

    localparam logic [1:0] RD_LAST = 2'(MEM_RD_LAT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_rd_cnt;
    logic              r_write;
    logic              r_signed;
    logic              r_fault;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdword;

    logic              w_accept;
    logic              w_fault;
    logic              w_rd_last;
    logic [31:0]       w_merged;
    logic [31:0]       w_load;

    assign w_accept  = ReqValid && (r_state == ST_IDLE);
    assign w_fault   = req_faults(ReqSize, ReqAddr[1:0]);
    assign w_rd_last = (r_state == ST_RD) && (r_rd_cnt == RD_LAST);

    byte_lane_unit u_lanes (
        .i_word   (r_rdword),
        .i_lane   (r_addr[1:0]),
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_wdata  (r_wdata),
        .o_merged (w_merged),
        .o_load   (w_load)
    );

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: faults skip memory, word stores skip the read phase
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_fault) begin
                        w_state_nxt = ST_RESP;
                    end else if (ReqWrite && (ReqSize == SZ_WORD)) begin
                        w_state_nxt = ST_WR;
                    end else begin
                        w_state_nxt = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (w_rd_last) begin
                    w_state_nxt = r_write ? ST_WR : ST_RESP;
                end
            end
            ST_WR:   w_state_nxt = ST_RESP;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request latches, read-phase counter and captured read word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_cnt <= 2'd0;
            r_write  <= 1'b0;
            r_signed <= 1'b0;
            r_fault  <= 1'b0;
            r_size   <= 2'b00;
            r_addr   <= '0;
            r_wdata  <= 32'h0;
            r_rdword <= 32'h0;
        end else begin
            if (r_state == ST_RD) begin
                r_rd_cnt <= r_rd_cnt + 2'd1;
            end else begin
                r_rd_cnt <= 2'd0;
            end
            if (w_accept) begin
                r_write  <= ReqWrite;
                r_signed <= ReqSigned;
                r_fault  <= w_fault;
                r_size   <= ReqSize;
                r_addr   <= ReqAddr;
                r_wdata  <= ReqWData;
            end
            if (w_rd_last) begin
                r_rdword <= MemReadData;
            end
        end
    end

    // Outputs decoded from state so memory strobes fall with reset immediately
    always_comb begin
        ReqReady     = (r_state == ST_IDLE);
        MemRead      = (r_state == ST_RD);
        MemWrite     = (r_state == ST_WR);
        MemAddress   = '0;
        MemWriteData = 32'h0;
        RespValid    = (r_state == ST_RESP);
        RespFault    = 1'b0;
        RespRData    = 32'h0;
        if ((r_state == ST_RD) || (r_state == ST_WR)) begin
            MemAddress = {r_addr[ADDR_W-1:2], 2'b00};
        end
        if (r_state == ST_WR) begin
            MemWriteData = w_merged;
        end
        if (r_state == ST_RESP) begin
            RespFault = r_fault;
            if (!r_write && !r_fault) begin
                RespRData = w_load;
            end
        end
    end

endmodule
